// File: rtl/dmem_pkg.sv
// Shared types and defaults for the OBI data-memory responder.
// Byte-granular writes are selected by defining DMEM_BYTE_WRITE_EN (see dmem_obi_slave).
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int CNT_W               = 4;
    localparam int DEF_ADDR_WIDTH      = 10;
    localparam int DEF_WAIT_CYCLES     = 0;

endpackage

// File: rtl/dmem_sram_array.sv
// Single-port word storage: synchronous byte-enabled write, registered read.
// Contents are not reset; only the read register is.
module dmem_sram_array #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read register holds its value between reads so the responder can hold rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             rdata <= '0;
        else if (en && !we)     rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_obi_slave.sv
// OBI data-memory responder: one request at a time, programmable wait states.
// Define DMEM_BYTE_WRITE_EN for per-byte writes; otherwise any nonzero be writes the full word.
module dmem_obi_slave
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        addr_q;
    logic               we_q;
    logic [3:0]         be_q;
    logic [31:0]        wdata_q;
    logic               zero_q;
    logic               capture;
    logic               access;
    logic               in_range;
    logic [3:0]         be_eff;
    logic [31:0]        sram_rdata;

    assign in_range = (addr_q[31:ADDR_WIDTH] == '0);

`ifdef DMEM_BYTE_WRITE_EN
    assign be_eff = be_q;
`else
    assign be_eff = (be_q != 4'b0000) ? 4'b1111 : 4'b0000;
`endif

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_req_i) begin
                    capture = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = GRANT;
            end
            GRANT: begin
                access  = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (data_req_i) begin
                    capture = 1'b1;
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            we_q          <= 1'b0;
            be_q          <= '0;
            wdata_q       <= '0;
            data_gnt_o    <= 1'b0;
            data_rvalid_o <= 1'b0;
            data_err_o    <= 1'b0;
            zero_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            // Pulses are registered from the next state so they line up with the state itself.
            data_gnt_o    <= (state_d == GRANT);
            data_rvalid_o <= (state_d == RESP);
            if (capture) begin
                addr_q  <= data_addr_i;
                we_q    <= data_we_i;
                be_q    <= data_be_i;
                wdata_q <= data_wdata_i;
                cnt_q   <= CNT_W'(WAIT_CYCLES);
            end else if (state_q == WAIT && cnt_q != '0) begin
                cnt_q   <= cnt_q - CNT_W'(1);
            end
            if (access) begin
                data_err_o <= !in_range;
                zero_q     <= we_q || !in_range;
            end
        end
    end

    dmem_sram_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sram (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (access && in_range),
        .we    (we_q),
        .be    (be_eff),
        .addr  (addr_q[ADDR_WIDTH-1:0]),
        .wdata (wdata_q),
        .rdata (sram_rdata)
    );

    // Writes and out-of-range accesses return zero; the read register keeps the last word otherwise.
    assign data_rdata_o = zero_q ? 32'h0 : sram_rdata;

endmodule

// File: doc/dmem_obi_slave.md
# dmem_obi_slave

Single-port data-memory responder on the core's data bus, directly downstream of the load/store unit. Accepts one request at a time on the req/gnt/rvalid handshake, inserts a programmable number of wait states, commits byte-masked writes or performs word reads, and returns one response per grant. It is the standard data-side memory model for simulation and FPGA builds.

## Interface
- ADDR_WIDTH, 10: word-address bits implemented; depth = 2**ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 0: extra wait states between request capture and grant (0..15).
- clk  input  1  clock, all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_req_i  input  1  request valid (level; may stay high across transactions).
- data_addr_i  input  32  word address (byte address already shifted right by 2 upstream).
- data_we_i  input  1  1 = write, 0 = read.
- data_be_i  input  4  byte enables; bit k selects bits [8k+7:8k].
- data_wdata_i  input  32  write data, lanes pre-aligned by the requester.
- data_gnt_o  output  1  one-cycle grant pulse.
- data_rvalid_o  output  1  one-cycle response-valid pulse.
- data_rdata_o  output  32  read data, valid while data_rvalid_o = 1.
- data_err_o  output  1  out-of-range flag, valid while data_rvalid_o = 1.

## Operation
- States: IDLE, WAIT, GRANT, RESP. Reset state IDLE.
- IDLE: edge with data_req_i = 1 captures addr/we/be/wdata into request registers, loads wait counter with WAIT_CYCLES, goes to WAIT. Otherwise stays.
- WAIT: counter != 0 -> decrement, stay; counter == 0 -> GRANT.
- GRANT: data_gnt_o = 1. Exit edge performs the access on captured request and goes to RESP.
- RESP: data_rvalid_o = 1. Exit edge: data_req_i = 1 -> capture new request, go to WAIT; else IDLE.
- Inputs are ignored in WAIT and GRANT; the captured request alone determines the access.
- In range: captured addr[31:ADDR_WIDTH] == 0. Out of range: no write, data_rdata_o = 0, data_err_o = 1.
- Read: data_rdata_o = full stored word, be ignored. Write: data_rdata_o = 0, data_err_o = 0 when in range.
- Write with be = 4'b0000: no memory change; response still issued.
- Memory contents are not reset; uninitialised words read X in simulation.

## Timing
- Reset values: data_gnt_o 0, data_rvalid_o 0, data_rdata_o 0, data_err_o 0, counter 0, state IDLE.
- Request sampled at edge N: data_gnt_o high for cycle after edge N+1+WAIT_CYCLES; write commits and data_rdata_o/data_rvalid_o update at edge N+2+WAIT_CYCLES; rvalid high for exactly one cycle.
- Back-to-back with req held high: one transaction per 3+WAIT_CYCLES cycles; no idle cycle between RESP and next WAIT.
- data_rdata_o and data_err_o hold last value when rvalid is low.
- Reset asserted mid-transaction: immediate return to IDLE, outputs to reset values; a write not yet past the GRANT exit edge is not committed.
- Outputs are all registered; no combinational path from inputs to outputs.

## Configuration
- DMEM_BYTE_WRITE_EN defined: writes update only bytes with data_be_i bit set.
- Not defined: any write with be != 0 writes all 32 bits from data_wdata_i; be = 0 still writes nothing.

## Structure
- Package dmem_pkg: state enum type (IDLE/WAIT/GRANT/RESP), wait-counter width constant (4), default ADDR_WIDTH and WAIT_CYCLES.
- Sub-module dmem_sram_array: storage only, one port, synchronous write with per-byte enable, registered read; instantiated once, FSM and range check stay in top.

## Test plan
- WAIT_CYCLES=0: write 0xDEADBEEF at addr 5 be 4'b1111, then read addr 5 -> gnt 1 cycle after capture, rvalid next cycle, rdata 0xDEADBEEF, err 0.
- Byte write (macro defined): preload addr 2 = 0x11223344, write 0x00AA0000 be 4'b0100 -> read returns 0x11AA3344; macro undefined -> 0x00AA0000.
- WAIT_CYCLES=3: req sampled at edge N -> gnt cycle after edge N+4, rvalid cycle after edge N+5.
- Out of range (ADDR_WIDTH=10): write addr 0x400 then read addr 0x400 -> rvalid with err 1, rdata 0, addr 0 unchanged.
- req held high for 4 reads, WAIT_CYCLES=0 -> exactly 4 gnt and 4 rvalid pulses, period 3 cycles.
- Reset pulsed while in WAIT for a write to addr 7 -> outputs 0, state IDLE, subsequent read of addr 7 returns prior contents.
